// File: rtl/word_comp_seq.sv
// Multi-cycle word comparator: scans two latched operands one lane per clock, MSB lane first.
// Optional mismatch bit counter enabled by defining WORD_COMP_MISMATCH_CNT_EN.
module word_comp_seq #(
    parameter int DATA_WIDTH = 32,
    parameter int LANE_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  signed_mode,
    input  logic [DATA_WIDTH-1:0] word_a,
    input  logic [DATA_WIDTH-1:0] word_b,
    output logic [DATA_WIDTH-1:0] word_comp,
    output logic                  eq,
    output logic                  gt,
    output logic                  lt,
    output logic                  busy,
    output logic                  done
`ifdef WORD_COMP_MISMATCH_CNT_EN
    ,
    output logic [$clog2(DATA_WIDTH+1)-1:0] mismatch_cnt
`endif
);

    localparam int NUM_LANES = DATA_WIDTH / LANE_WIDTH;
    localparam int LANE_W    = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIN  = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] a_q, a_d;
    logic [DATA_WIDTH-1:0] b_q, b_d;
    logic                  sm_q, sm_d;
    logic [DATA_WIDTH-1:0] comp_q, comp_d;
    logic                  gt_q, gt_d;
    logic                  lt_q, lt_d;
    logic                  eq_q, eq_d;
    logic                  done_q, done_d;
    logic [LANE_W-1:0]     lane_q, lane_d;

    logic [LANE_WIDTH-1:0] lane_a, lane_b, cmp_a, cmp_b;
    int                    lane_base;

`ifdef WORD_COMP_MISMATCH_CNT_EN
    localparam int CNT_W = $clog2(DATA_WIDTH+1);
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [LANE_WIDTH-1:0] lane_diff;
`endif

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sm_d    = sm_q;
        comp_d  = comp_q;
        gt_d    = gt_q;
        lt_d    = lt_q;
        eq_d    = eq_q;
        done_d  = 1'b0;
        lane_d  = lane_q;

        lane_base = int'(lane_q) * LANE_WIDTH;
        lane_a    = a_q[lane_base +: LANE_WIDTH];
        lane_b    = b_q[lane_base +: LANE_WIDTH];
        cmp_a     = lane_a;
        cmp_b     = lane_b;
        // Flipping the sign bits maps two's-complement order onto unsigned order.
        if (sm_q && (lane_q == LANE_W'(NUM_LANES-1))) begin
            cmp_a[LANE_WIDTH-1] = ~lane_a[LANE_WIDTH-1];
            cmp_b[LANE_WIDTH-1] = ~lane_b[LANE_WIDTH-1];
        end

`ifdef WORD_COMP_MISMATCH_CNT_EN
        cnt_d     = cnt_q;
        lane_diff = lane_a ^ lane_b;
`endif

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    a_d     = word_a;
                    b_d     = word_b;
                    sm_d    = signed_mode;
                    comp_d  = '0;
                    gt_d    = 1'b0;
                    lt_d    = 1'b0;
                    eq_d    = 1'b0;
                    lane_d  = LANE_W'(NUM_LANES-1);
                    state_d = S_RUN;
`ifdef WORD_COMP_MISMATCH_CNT_EN
                    cnt_d   = '0;
`endif
                end
            end
            S_RUN: begin
                comp_d[lane_base +: LANE_WIDTH] = ~(lane_a ^ lane_b);
                if (!gt_q && !lt_q && (cmp_a != cmp_b)) begin
                    gt_d = (cmp_a > cmp_b);
                    lt_d = (cmp_a < cmp_b);
                end
`ifdef WORD_COMP_MISMATCH_CNT_EN
                for (int i = 0; i < LANE_WIDTH; i++) begin
                    cnt_d = cnt_d + CNT_W'(lane_diff[i]);
                end
`endif
                if (lane_q == '0) begin
                    state_d = S_FIN;
                end else begin
                    lane_d = lane_q - LANE_W'(1);
                end
            end
            S_FIN: begin
                done_d  = 1'b1;
                eq_d    = ~gt_q & ~lt_q;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sm_q    <= 1'b0;
            comp_q  <= '0;
            gt_q    <= 1'b0;
            lt_q    <= 1'b0;
            eq_q    <= 1'b0;
            done_q  <= 1'b0;
            lane_q  <= '0;
`ifdef WORD_COMP_MISMATCH_CNT_EN
            cnt_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sm_q    <= sm_d;
            comp_q  <= comp_d;
            gt_q    <= gt_d;
            lt_q    <= lt_d;
            eq_q    <= eq_d;
            done_q  <= done_d;
            lane_q  <= lane_d;
`ifdef WORD_COMP_MISMATCH_CNT_EN
            cnt_q   <= cnt_d;
`endif
        end
    end

    assign word_comp = comp_q;
    assign eq        = eq_q;
    assign gt        = gt_q;
    assign lt        = lt_q;
    assign busy      = (state_q == S_RUN);
    assign done      = done_q;
`ifdef WORD_COMP_MISMATCH_CNT_EN
    assign mismatch_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_word_comp_seq.sv
// Directed self-checking bench for word_comp_seq (DATA_WIDTH=32, LANE_WIDTH=8).
// Mismatch counter checks compile in when WORD_COMP_MISMATCH_CNT_EN is defined.
module tb_word_comp_seq;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        signed_mode;
    logic [31:0] word_a;
    logic [31:0] word_b;
    logic [31:0] word_comp;
    logic        eq, gt, lt, busy, done;
`ifdef WORD_COMP_MISMATCH_CNT_EN
    logic [5:0]  mismatch_cnt;
`endif

    int n_cmp  = 0;
    int n_fail = 0;

    word_comp_seq #(.DATA_WIDTH(32), .LANE_WIDTH(8)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .signed_mode (signed_mode),
        .word_a      (word_a),
        .word_b      (word_b),
        .word_comp   (word_comp),
        .eq          (eq),
        .gt          (gt),
        .lt          (lt),
        .busy        (busy),
        .done        (done)
`ifdef WORD_COMP_MISMATCH_CNT_EN
        ,
        .mismatch_cnt(mismatch_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Accepts one operation and returns once done is seen (or the budget expires).
    task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic sm,
                         output int lat, output int busy_cnt);
        word_a      = a;
        word_b      = b;
        signed_mode = sm;
        start       = 1'b1;
        tick();
        start    = 1'b0;
        lat      = 0;
        busy_cnt = 0;
        while (!done && lat < 20) begin
            if (busy) busy_cnt++;
            tick();
            lat++;
        end
        n_cmp++;
        if (done !== 1'b1) begin
            n_fail++;
            $display("FAIL done_timeout: done=%b after %0d edges, required 1", done, lat);
        end
    endtask

    task automatic check_flags(input string tag, input logic [31:0] comp_exp,
                               input logic eq_exp, input logic gt_exp, input logic lt_exp);
        n_cmp++;
        if (word_comp !== comp_exp) begin
            n_fail++;
            $display("FAIL %s word_comp: got %h required %h", tag, word_comp, comp_exp);
        end
        n_cmp++;
        if ({eq, gt, lt} !== {eq_exp, gt_exp, lt_exp}) begin
            n_fail++;
            $display("FAIL %s eq/gt/lt: got %b%b%b required %b%b%b", tag, eq, gt, lt,
                     eq_exp, gt_exp, lt_exp);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b0;
        signed_mode = 1'b0;
        word_a = '0;
        word_b = '0;
        tick();
        tick();
        reset = 1'b0;
        n_cmp++;
        if ({busy, done} !== 2'b00) begin
            n_fail++;
            $display("FAIL reset busy/done: got %b%b required 00", busy, done);
        end
        check_flags("reset", 32'h0, 1'b0, 1'b0, 1'b0);
        tick();
        n_cmp++;
        if ({busy, done} !== 2'b00) begin
            n_fail++;
            $display("FAIL idle_after_reset busy/done: got %b%b required 00", busy, done);
        end
    endtask

    task automatic test_equal();
        int lat, bc;
        do_op(32'hDEADBEEF, 32'hDEADBEEF, 1'b0, lat, bc);
        n_cmp++;
        if (lat !== 5) begin
            n_fail++;
            $display("FAIL equal latency: got %0d edges required 5", lat);
        end
        n_cmp++;
        if (bc !== 4) begin
            n_fail++;
            $display("FAIL equal busy_cycles: got %0d required 4", bc);
        end
        check_flags("equal", 32'hFFFFFFFF, 1'b1, 1'b0, 1'b0);
`ifdef WORD_COMP_MISMATCH_CNT_EN
        n_cmp++;
        if (mismatch_cnt !== 6'd0) begin
            n_fail++;
            $display("FAIL equal mismatch_cnt: got %0d required 0", mismatch_cnt);
        end
`endif
        tick();
        n_cmp++;
        if (done !== 1'b0) begin
            n_fail++;
            $display("FAIL equal done_width: got %b required 0", done);
        end
        check_flags("equal_hold", 32'hFFFFFFFF, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_msb();
        int lat, bc;
        do_op(32'h80000000, 32'h7FFFFFFF, 1'b0, lat, bc);
        check_flags("msb_unsigned", 32'h00000000, 1'b0, 1'b1, 1'b0);
`ifdef WORD_COMP_MISMATCH_CNT_EN
        n_cmp++;
        if (mismatch_cnt !== 6'd32) begin
            n_fail++;
            $display("FAIL msb mismatch_cnt: got %0d required 32", mismatch_cnt);
        end
`endif
        do_op(32'h80000000, 32'h7FFFFFFF, 1'b1, lat, bc);
        check_flags("msb_signed", 32'h00000000, 1'b0, 1'b0, 1'b1);
        do_op(32'hFFFFFFFE, 32'h00000003, 1'b1, lat, bc);
        check_flags("neg_vs_pos_signed", 32'h00000002, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_lane0();
        int lat, bc;
        do_op(32'h12345678, 32'h12345679, 1'b0, lat, bc);
        n_cmp++;
        if (lat !== 5) begin
            n_fail++;
            $display("FAIL lane0 latency: got %0d edges required 5", lat);
        end
        check_flags("lane0", 32'hFFFFFFFE, 1'b0, 1'b0, 1'b1);
`ifdef WORD_COMP_MISMATCH_CNT_EN
        n_cmp++;
        if (mismatch_cnt !== 6'd1) begin
            n_fail++;
            $display("FAIL lane0 mismatch_cnt: got %0d required 1", mismatch_cnt);
        end
`endif
    endtask

    task automatic test_ignore_start();
        int dcnt = 0;
        logic [31:0] comp_s = '0;
        logic [2:0]  flags_s = '0;
        word_a = 32'h1;
        word_b = 32'h2;
        signed_mode = 1'b0;
        start = 1'b1;
        tick();
        for (int c = 0; c < 16; c++) begin
            if (done) begin
                dcnt++;
                if (c == 5) begin
                    comp_s  = word_comp;
                    flags_s = {eq, gt, lt};
                end
            end
            start = (c == 1 || c == 4);
            if (start) begin
                word_a = 32'h9 + 32'(c);
                word_b = 32'h3;
            end
            tick();
        end
        start = 1'b0;
        n_cmp++;
        if (dcnt !== 1) begin
            n_fail++;
            $display("FAIL ignore_start done_count: got %0d required 1", dcnt);
        end
        n_cmp++;
        if (comp_s !== 32'hFFFFFFFC) begin
            n_fail++;
            $display("FAIL ignore_start word_comp: got %h required fffffffc", comp_s);
        end
        n_cmp++;
        if (flags_s !== 3'b001) begin
            n_fail++;
            $display("FAIL ignore_start eq/gt/lt: got %b required 001", flags_s);
        end
    endtask

    task automatic test_reset_mid();
        int dcnt = 0;
        int lat, bc;
        word_a = 32'hFF000000;
        word_b = 32'h00000000;
        signed_mode = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        n_cmp++;
        if ({busy, gt} !== 2'b11) begin
            n_fail++;
            $display("FAIL mid_run busy/gt: got %b%b required 11", busy, gt);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n_cmp++;
        if ({busy, done} !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_mid busy/done: got %b%b required 00", busy, done);
        end
        check_flags("reset_mid", 32'h0, 1'b0, 1'b0, 1'b0);
        for (int c = 0; c < 10; c++) begin
            if (done || busy) dcnt++;
            tick();
        end
        n_cmp++;
        if (dcnt !== 0) begin
            n_fail++;
            $display("FAIL reset_mid activity_after_reset: got %0d cycles required 0", dcnt);
        end
        do_op(32'h00000003, 32'h00000003, 1'b0, lat, bc);
        n_cmp++;
        if (lat !== 5) begin
            n_fail++;
            $display("FAIL reset_mid recover_latency: got %0d required 5", lat);
        end
        check_flags("reset_mid_recover", 32'hFFFFFFFF, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_back_to_back();
        logic exp_done;
        word_a = 32'h0;
        word_b = 32'h0;
        signed_mode = 1'b0;
        start = 1'b1;
        for (int e = 1; e <= 24; e++) begin
            tick();
            exp_done = (e % 6 == 0);
            n_cmp++;
            if (done !== exp_done) begin
                n_fail++;
                $display("FAIL b2b done@edge%0d: got %b required %b", e, done, exp_done);
            end
            if (exp_done) begin
                check_flags("b2b_result", 32'hFFFFFFFF, 1'b1, 1'b0, 1'b0);
            end
        end
        start = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_equal();
        test_msb();
        test_lane0();
        test_ignore_start();
        test_reset_mid();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
